// File: rtl/seg_pkg.sv
// Shared definitions for seven-segment display blocks: digit encodings,
// buffer entry layout and the hex-to-segment decode function.
package seg_pkg;

    localparam int unsigned MaxDigits = 8;
    localparam int unsigned DigIdxW   = 3;

    // Active-high segment patterns {a,b,c,d,e,f,g,dp}; dp bit is always 0 here.
    typedef enum logic [7:0] {
        SegDig0 = 8'hFC,
        SegDig1 = 8'h60,
        SegDig2 = 8'hDA,
        SegDig3 = 8'hF2,
        SegDig4 = 8'h66,
        SegDig5 = 8'hB6,
        SegDig6 = 8'hBE,
        SegDig7 = 8'hE0,
        SegDig8 = 8'hFE,
        SegDig9 = 8'hF6,
        SegDigA = 8'hEE,
        SegDigB = 8'h3E,
        SegDigC = 8'h9C,
        SegDigD = 8'h7A,
        SegDigE = 8'h9E,
        SegDigF = 8'h8E
    } seg_digit_e;

    typedef enum logic {PhBlank, PhShow} scan_phase_e;

    typedef struct packed {
        logic       en;
        logic       dp;
        logic [3:0] data;
    } seg_entry_t;

    function automatic logic [7:0] seg_hex_decode_f(input logic [3:0] nibble);
        seg_digit_e d;
        d = SegDig0;
        case (nibble)
            4'h0: d = SegDig0;
            4'h1: d = SegDig1;
            4'h2: d = SegDig2;
            4'h3: d = SegDig3;
            4'h4: d = SegDig4;
            4'h5: d = SegDig5;
            4'h6: d = SegDig6;
            4'h7: d = SegDig7;
            4'h8: d = SegDig8;
            4'h9: d = SegDig9;
            4'hA: d = SegDigA;
            4'hB: d = SegDigB;
            4'hC: d = SegDigC;
            4'hD: d = SegDigD;
            4'hE: d = SegDigE;
            4'hF: d = SegDigF;
            default: d = SegDig0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    assign pattern = seg_hex_decode_f(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit display with
// a per-digit buffer, blanking window per slot and a write port that stalls on the lit digit.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_idx,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       wr_en,
    output logic [7:0] o_seg,
    output logic [7:0] o_an,
    output logic       scan_tick
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [DigIdxW-1:0] dig_q, dig_d;
    seg_entry_t         digit_buf_q [MaxDigits];
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         an_q, an_d;
    logic               tick_q;

    logic        slot_end;
    logic        frame_wrap;
    logic        wr_fire;
    scan_phase_e phase;
    seg_entry_t  cur;
    logic [7:0]  pattern;

    assign slot_end   = (cnt_q == CntW'(SCAN_DIV - 1));
    assign frame_wrap = slot_end && (dig_q == DigIdxW'(NUM_DIGITS - 1));
    assign phase      = (cnt_q < CntW'(BLANK_CYCLES)) ? PhBlank : PhShow;

    // Only the digit currently lit is protected; out-of-range indices are accepted and dropped.
    assign wr_ready = !((phase == PhShow) && (wr_idx == dig_q));
    assign wr_fire  = wr_valid && wr_ready && (32'(wr_idx) < NUM_DIGITS);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        dig_d = dig_q;
        if (slot_end) begin
            cnt_d = '0;
            dig_d = frame_wrap ? '0 : dig_q + DigIdxW'(1);
        end
    end

    assign cur = digit_buf_q[dig_q];

    seg_hex_decode u_hex_decode (
        .nibble  (cur.data),
        .pattern (pattern)
    );

    always_comb begin
        seg_d = 8'hFF;
        an_d  = 8'hFF;
        if ((phase == PhShow) && cur.en) begin
            an_d  = ~(8'b1 << dig_q);
            seg_d = ~{pattern[7:1], cur.dp};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dig_q  <= '0;
            seg_q  <= 8'hFF;
            an_q   <= 8'hFF;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            tick_q <= frame_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MaxDigits; i++) begin
                digit_buf_q[i] <= '0;
            end
        end else if (wr_fire) begin
            digit_buf_q[wr_idx] <= '{en: wr_en, dp: wr_dp, data: wr_data};
        end
    end

    assign o_seg     = seg_q;
    assign o_an      = an_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random writes,
// compared every cycle against a frame-position model of the display.
module tb_seg_scan_ctrl;

    localparam int unsigned ND    = 8;
    localparam int unsigned SD    = 8;
    localparam int unsigned BC    = 2;
    localparam int unsigned FRAME = ND * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_idx = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_dp = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] o_seg;
    logic [7:0] o_an;
    logic       scan_tick;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_dp     (wr_dp),
        .wr_en     (wr_en),
        .o_seg     (o_seg),
        .o_an      (o_an),
        .scan_tick (scan_tick)
    );

    int checks = 0;
    int passes = 0;
    int n = 0;  // clock edges since reset release

    logic [7:0] hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    logic       m_en   [ND];
    logic       m_dp   [ND];
    logic [3:0] m_data [ND];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h (n=%0d)", tag, obs, exp, n);
    endtask

    task automatic clear_model();
        for (int i = 0; i < ND; i++) begin
            m_en[i] = 1'b0;
            m_dp[i] = 1'b0;
            m_data[i] = 4'd0;
        end
        n = 0;
    endtask

    function automatic logic ready_at(int k, logic [2:0] idx);
        int pos = k % SD;
        int slot = (k / SD) % ND;
        return !(pos >= BC && int'(idx) == slot);
    endfunction

    // Display a state k edges after release produces on the following edge.
    task automatic disp_at(input int k, output logic [7:0] an, output logic [7:0] seg);
        int pos = k % SD;
        int slot = (k / SD) % ND;
        an = 8'hFF;
        seg = 8'hFF;
        if (pos >= BC && m_en[slot]) begin
            an = 8'(255 - (1 << slot));
            seg = 8'(255 - (int'(hex_tab[m_data[slot]]) + int'(m_dp[slot])));
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(output logic acc);
        logic rdy;
        logic [7:0] ea, es;
        logic et;
        #1;
        rdy = ready_at(n, wr_idx);
        check("wr_ready", 8'(wr_ready), 8'(rdy));
        acc = wr_valid && rdy;
        disp_at(n, ea, es);
        @(posedge clk);
        if (acc) begin
            m_en[wr_idx] = wr_en;
            m_dp[wr_idx] = wr_dp;
            m_data[wr_idx] = wr_data;
        end
        n++;
        et = (n % FRAME == 0);
        #1;
        check("o_an", o_an, ea);
        check("o_seg", o_seg, es);
        check("scan_tick", 8'(scan_tick), 8'(et));
        @(negedge clk);
    endtask

    task automatic idle_until(input int m);
        logic a;
        int guard = 0;
        wr_valid = 1'b0;
        while (n % FRAME != m && guard < 2 * FRAME) begin
            tick(a);
            guard++;
        end
    endtask

    task automatic write(input logic [2:0] idx, input logic [3:0] data, input logic dp,
                         input logic en);
        logic acc = 1'b0;
        int guard = 0;
        wr_idx = idx;
        wr_data = data;
        wr_dp = dp;
        wr_en = en;
        wr_valid = 1'b1;
        while (!acc && guard < 2 * SD) begin
            tick(acc);
            guard++;
        end
        check("write_accept", 8'(acc), 8'd1);
        wr_valid = 1'b0;
    endtask

    task automatic reset_hold(input int cycles);
        wr_valid = 1'b0;
        wr_idx = 3'd0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            check("rst_an", o_an, 8'hFF);
            check("rst_seg", o_seg, 8'hFF);
            check("rst_tick", 8'(scan_tick), 8'd0);
            check("rst_ready", 8'(wr_ready), 8'd1);
            @(negedge clk);
        end
        clear_model();
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        logic pend;
        int ticks;

        clear_model();
        // 1. reset, then empty buffer shows dark in slot 0
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", o_an, 8'hFF);
        check("async_rst_seg", o_seg, 8'hFF);
        @(negedge clk);
        reset_hold(3);
        idle_until(4);
        check("s1_empty_an", o_an, 8'hFF);
        check("s1_empty_seg", o_seg, 8'hFF);

        // 2. digit 0 written during BLANK
        idle_until(0);
        write(3'd0, 4'h3, 1'b0, 1'b1);
        idle_until(4);
        check("s2_an", o_an, 8'hFE);
        check("s2_seg", o_seg, 8'h0D);

        // 3. digit 5 with decimal point
        write(3'd5, 4'hA, 1'b1, 1'b1);
        idle_until(44);
        check("s3_an", o_an, 8'hDF);
        check("s3_seg", o_seg, 8'h10);

        // 4. stall on the lit digit
        write(3'd2, 4'h7, 1'b0, 1'b1);
        idle_until(20);
        check("s4_old_an", o_an, 8'hFB);
        check("s4_old_seg", o_seg, 8'h1F);
        wr_idx = 3'd2;
        wr_data = 4'h1;
        wr_dp = 1'b0;
        wr_en = 1'b1;
        wr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("s4_stall", 8'(wr_ready), 8'd0);
            tick(acc);
            check("s4_stall_seg", o_seg, 8'h1F);
        end
        #1;
        check("s4_release", 8'(wr_ready), 8'd1);
        tick(acc);
        check("s4_accepted", 8'(acc), 8'd1);
        wr_valid = 1'b0;
        idle_until(20);
        check("s4_new_an", o_an, 8'hFB);
        check("s4_new_seg", o_seg, 8'h9F);

        // 5. frame timing and dark digit 7
        ticks = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(acc);
            if (scan_tick === 1'b1) ticks++;
            if (n % FRAME == 63) check("s5_dig7_dark", o_an, 8'hFF);
        end
        check("s5_tick_count", 8'(ticks), 8'd2);

        // random writes against the model
        pend = 1'b0;
        for (int k = 0; k < 400 || (pend && k < 420); k++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                wr_idx = 3'($urandom_range(0, 7));
                wr_data = 4'($urandom_range(0, 15));
                wr_dp = 1'($urandom_range(0, 1));
                wr_en = ($urandom_range(0, 3) != 0);
            end
            wr_valid = pend;
            tick(acc);
            if (acc) pend = 1'b0;
        end
        wr_valid = 1'b0;

        // 6. async reset mid-slot
        write(3'd4, 4'h5, 1'b1, 1'b1);
        write(3'd0, 4'h8, 1'b0, 1'b1);
        idle_until(37);
        check("s6_pre_an", o_an, 8'hEF);
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_an", o_an, 8'hFF);
        check("s6_async_seg", o_seg, 8'hFF);
        @(negedge clk);
        reset_hold(2);
        idle_until(4);
        check("s6_cleared_an", o_an, 8'hFF);
        idle_until(36);
        check("s6_cleared_an4", o_an, 8'hFF);
        idle_until(0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an 8-digit common-anode seven-segment display that shares one segment bus across all digits.
- Holds a per-digit buffer of {enable, dp, hex nibble}, loaded through a valid/ready write port.
- Cycles through the digits, inserting a blank window at each digit change to suppress ghosting.
- Stalls any write to the digit currently lit, so the display never changes mid-slot.
- Sits between the display pins and any producer (counter, CPU MMIO, debug logic).

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8); digit index width is 3 bits.
SCAN_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+1).
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (>= 1).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
wr_valid  input  1  write request
wr_ready  output  1  write accepted this cycle when wr_valid && wr_ready
wr_idx  input  3  target digit
wr_data  input  4  hex value 0..F
wr_dp  input  1  decimal point on
wr_en  input  1  digit enable; 0 = digit stays dark
o_seg  output  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered
o_an  output  8  digit select, bit i = digit i, active-low, registered
scan_tick  output  1  one-cycle pulse at each frame wrap, registered

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - o_seg=8'hFF, o_an=8'hFF, scan_tick=0.
  - Slot counter cnt=0, digit pointer dig=0.
  - All buffer entries cleared to {en=0, dp=0, data=0}.
- Counter:
  - cnt counts 0..SCAN_DIV-1; width $clog2(SCAN_DIV).
  - When cnt==SCAN_DIV-1: cnt returns to 0 and dig increments.
  - dig wraps from NUM_DIGITS-1 to 0; when it does, scan_tick is 1 on the following cycle.
- Phase (combinational from cnt):
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW otherwise, i.e. SCAN_DIV-BLANK_CYCLES cycles per slot.
- Outputs (registered, one cycle after the cnt/dig/buffer state that produces them):
  - BLANK: o_an=8'hFF, o_seg=8'hFF.
  - SHOW with buf[dig].en=1: o_an=~(8'b1<<dig); o_seg=~{decode(buf[dig].data)[7:1], buf[dig].dp}.
  - SHOW with en=0: o_an=8'hFF, o_seg=8'hFF.
- Decode (MSB=a, before inversion), 0-7 matching the existing digit encoding:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
  - Bit 0 of the decode is always 0; dp comes from the buffer.
- Write port:
  - wr_ready = !(phase==SHOW && wr_idx==dig). Combinational; may depend on wr_idx.
  - On accept: buf[wr_idx] <= {wr_en, wr_dp, wr_data}, visible in the next cycle's output computation.
  - wr_idx >= NUM_DIGITS: ready=1, accepted, dropped (no state change).
  - A write accepted in the last BLANK cycle of its own digit shows on that slot's first SHOW output.
  - A write stalled during the last SHOW cycle becomes ready the next cycle, because dig has advanced.
- At most one write per cycle. No write is lost; the producer holds wr_valid and payload until accepted.
- Reset asserted mid-slot aborts the scan and any pending write. After release, scanning restarts at digit 0, cnt=0, BLANK.

Decomposition:
- Shared package seg_pkg:
  - Existing digit encoding enum, extended with 8..F.
  - Function seg_hex_decode_f(nibble) returning the 8-bit active-high pattern.
  - Typedef seg_entry_t {logic en; logic dp; logic [3:0] data}.
- One combinational sub-module seg_hex_decode wraps the function for reuse by other display blocks.
- Counter, buffer and output registers live in seg_scan_ctrl.

Test Plan:
Bench parameters: NUM_DIGITS=8, SCAN_DIV=8, BLANK_CYCLES=2.
1. Reset: hold rst_n=0 for 3 cycles → o_seg=8'hFF, o_an=8'hFF, scan_tick=0, wr_ready=1. Release → first SHOW output of digit 0 is all-1s (buffer empty).
2. Write idx=0, data=3, dp=0, en=1 during BLANK → in slot 0 SHOW, o_an=8'hFE, o_seg=8'h0D.
3. Write idx=5, data=A, dp=1, en=1 → in slot 5 SHOW, o_an=8'hDF, o_seg=8'h10.
4. Stall: assert write idx=2 at cnt=4 of slot 2 → wr_ready=0 through cnt=7; accepted at cnt=0 of slot 3; slot 2 keeps its old value until the next frame.
5. Frame timing → scan_tick pulses exactly once every 64 cycles. Digit 7 with en=0 gives o_an=8'hFF throughout slot 7.
6. Async reset at cnt=5 of slot 4 → o_an/o_seg=8'hFF without waiting for a clk edge; buffer cleared; restart at slot 0.
